nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//   Multi-cycle WIDTH-bit adder: one 4-bit ripple slice per clock, carry held
//   in a register between nibbles. Upstream: a valid/ready operand source.
//   Downstream: a valid/ready result sink.
//   Trades latency for area; the 4-bit slice is the only arithmetic in the block.
// PARAMETERS
//   WIDTH  16  operand/result width; multiple of 4, >= 8
//   NIBS   WIDTH/4 (localparam)  nibble count = RUN cycles per operation
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand transfer request
//   in_ready   out  1      block can accept operands this cycle
//   in_a       in   WIDTH  operand A (unsigned or two's complement)
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      carry-in to nibble 0
//   out_valid  out  1      result held and valid
//   out_ready  in   1      sink accepts result this cycle
//   out_sum    out  WIDTH  A+B+cin, mod 2^WIDTH
//   out_cout   out  1      carry out of bit WIDTH-1
//   out_ovf    out  1      signed overflow: a[MSB]==b[MSB] && sum[MSB]!=a[MSB]
// BEHAVIOUR
//   - Reset (rst=1 at edge): state=IDLE, nib_idx=0, carry=0.
//     out_valid=0; out_sum, out_cout and out_ovf are all 0.
//     in_ready=0 while rst is high.
//   - FSM states IDLE, RUN, DONE. in_ready = !rst && (IDLE || (DONE && out_ready)).
//   - Accept: in_valid && in_ready at edge E0. Latch a, b into shift regs;
//     carry<=in_cin; nib_idx<=0; clear out_sum; state->RUN.
//     Operands are ignored at all other edges.
//   - RUN: each edge computes the slice on a[3:0], b[3:0] and carry.
//     * Slice sum goes into the sum shift reg MSB nibble, which shifts right 4.
//     * The a and b shift regs shift right 4.
//     * carry <= slice cout; nib_idx++.
//     * At the edge where nib_idx==NIBS-1: state->DONE, out_valid<=1, out_cout<=slice cout.
//     * out_ovf is computed from the saved operand MSBs and the final sum MSB.
//   - Latency: out_valid rises NIBS edges after E0 (4 cycles at WIDTH=16).
//     Throughput is one op per NIBS+1 cycles when the sink is always ready.
//   - DONE: out_* are held stable until out_valid && out_ready.
//     * If in_valid is also high in that cycle: new accept, state->RUN, out_valid<=0
//       (back-to-back operation).
//     * Otherwise: state->IDLE, out_valid<=0.
//   - out_valid is never high outside DONE. The slice never sees X operands
//     outside RUN.
//   - nib_idx is $clog2(NIBS) bits and never wraps within an op; it is cleared on accept.
//   - Reset mid-RUN or mid-DONE abandons the op: no out_valid pulse.
//     in_ready=1 on the first cycle after rst falls.
//   - in_valid held high while in_ready=0: no effect; the operands are not sampled.
// STRUCTURE
//   - Shared package (adder_pkg):
//     * FSM state encoding st_e {IDLE, RUN, DONE}
//     * localparam NIB_W=4
//     * overflow helper function
//   - Sub-module adder_slice4: purely combinational 4-bit ripple slice.
//     * Inputs a[3:0], b[3:0], cin; outputs sum[3:0], cout.
//     * Carry chain c[i+1] = a&b | a&c[i] | b&c[i].
//     * sum[i] = a^b^c[i], using per-bit carry c[i], never cin for all bits.
//   - Top level holds the FSM, nib_idx counter, operand/sum shift regs, carry reg.
// TESTING (WIDTH=16, out_ready=1 unless stated)
//   1. 0x1234+0x4321, cin=0: out_sum=0x5555, cout=0, ovf=0.
//      out_valid is high exactly 4 cycles after accept.
//   2. 0xFFFF+0x0001, cin=0: sum=0x0000, cout=1, ovf=0.
//      The carry ripples across all 4 nibble boundaries.
//   3. 0x7FFF+0x0001, cin=0: sum=0x8000, cout=0, ovf=1.
//      0x8000+0x8000: sum=0x0000, cout=1, ovf=1.
//   4. 0x000F+0x0000, cin=1: sum=0x0010, cout=0.
//      This checks cin entering nibble 0 and the carry crossing into nibble 1.
//   5. Hold out_ready=0 for 10 cycles in DONE: out_* stable, in_ready=0 throughout.
//      Raise out_ready with in_valid=1: the result retires and the new op is accepted
//      on the same edge.
//   6. Assert rst for 1 cycle during RUN (nib_idx=2):
//      * out_valid never pulses; in_ready=1 after rst falls.
//      * The next op 0x00FF+0x0001 gives sum 0x0100.
//   Random: 1000 ops with random in_valid/out_ready gaps, scoreboarded against
//   {cout,sum}=a+b+cin.

Source files
------------

// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the nibble-serial adder: the controller state
//   encoding, the slice width, and the signed-overflow rule that the top level
//   applies to the finished result.
// ----------------------------------------------------------------------------
package adder_pkg;

    // Controller states: waiting for operands, stepping through nibbles,
    // and holding a finished result for the sink.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } st_e;

    // Width of the single arithmetic slice; everything is processed in
    // chunks of this many bits.
    localparam int NIB_W = 4;

    // Two's complement overflow: the operands share a sign and the result
    // sign differs from it.
    function automatic logic signedOverflow(input logic aMsb,
                                            input logic bMsb,
                                            input logic sumMsb);
        return (aMsb == bMsb) && (sumMsb != aMsb);
    endfunction

endpackage

// File: rtl/adder_slice4.sv
// ----------------------------------------------------------------------------
// adder_slice4
//   Purely combinational 4-bit ripple-carry slice, the only arithmetic in the
//   serial adder.
// Ports
//   a_i    [3:0]  operand A nibble
//   b_i    [3:0]  operand B nibble
//   cin_i         carry into bit 0
//   sum_o  [3:0]  nibble sum
//   cout_o        carry out of bit 3
// ----------------------------------------------------------------------------
module adder_slice4
    import adder_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    input  logic             cin_i,
    output logic [NIB_W-1:0] sum_o,
    output logic             cout_o
);

    // Each sum bit uses the carry rippled into that bit position, not the
    // slice carry-in, so the local carry vector lives inside the function.
    function automatic logic [NIB_W:0] rippleAdd(input logic [NIB_W-1:0] a,
                                                 input logic [NIB_W-1:0] b,
                                                 input logic             cin);
        logic [NIB_W:0]   c;
        logic [NIB_W-1:0] s;
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < NIB_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        return {c[NIB_W], s};
    endfunction

    // Combinational slice evaluation.
    always_comb begin
        {cout_o, sum_o} = rippleAdd(a_i, b_i, cin_i);
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// ----------------------------------------------------------------------------
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder. One nibble is added per clock by a single
//   4-bit slice; the carry is held in a register between nibbles. Operands
//   arrive over a valid/ready handshake and the result leaves over another.
// Ports
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   operand transfer request
//   in_ready_o   operands can be accepted this cycle
//   in_a_i       operand A  [WIDTH-1:0]
//   in_b_i       operand B  [WIDTH-1:0]
//   in_cin_i     carry into nibble 0
//   out_valid_o  result held and valid
//   out_ready_i  sink takes the result this cycle
//   out_sum_o    A+B+cin mod 2^WIDTH
//   out_cout_o   carry out of the MSB
//   out_ovf_o    signed overflow of the addition
// ----------------------------------------------------------------------------
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic             in_cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_sum_o,
    output logic             out_cout_o,
    output logic             out_ovf_o
);

    localparam int             NIBS     = WIDTH / NIB_W;
    localparam int             IDX_W    = $clog2(NIBS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

    st_e              state_q,  state_d;
    logic [IDX_W-1:0] nibIdx_q, nibIdx_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] aSh_q,    aSh_d;
    logic [WIDTH-1:0] bSh_q,    bSh_d;
    logic [WIDTH-1:0] sumSh_q,  sumSh_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;
    logic             aMsb_q,   aMsb_d;
    logic             bMsb_q,   bMsb_d;

    logic             accept;
    logic             lastNib;
    logic [NIB_W-1:0] sliceA;
    logic [NIB_W-1:0] sliceB;
    logic [NIB_W-1:0] sliceSum;
    logic             sliceCout;

    assign accept  = in_valid_i && in_ready_o;
    assign lastNib = (nibIdx_q == LAST_IDX);

    // The slice only sees live operand nibbles while running; at all other
    // times it is fed zeros so nothing undefined propagates through it.
    assign sliceA = (state_q == RUN) ? aSh_q[NIB_W-1:0] : '0;
    assign sliceB = (state_q == RUN) ? bSh_q[NIB_W-1:0] : '0;

    adder_slice4 u_slice (
        .a_i    (sliceA),
        .b_i    (sliceB),
        .cin_i  (carry_q),
        .sum_o  (sliceSum),
        .cout_o (sliceCout)
    );

    // State register; reset always returns to IDLE, abandoning any op.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Retiring a result and accepting a new operand pair
    // can happen on the same edge, which gives back-to-back operation.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (lastNib) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = accept ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs. Ready is withheld during reset and while a result
    // is stuck waiting for the sink.
    always_comb begin
        in_ready_o  = !rst_i && ((state_q == IDLE) ||
                                 ((state_q == DONE) && out_ready_i));
        out_valid_o = (state_q == DONE);
    end

    // Datapath next-state. On accept the operands are captured and the
    // result registers cleared; while running, each step consumes the low
    // nibble of both operands and inserts the slice sum at the top of the
    // sum register so that after NIBS steps it is fully aligned.
    always_comb begin
        nibIdx_d = nibIdx_q;
        carry_d  = carry_q;
        aSh_d    = aSh_q;
        bSh_d    = bSh_q;
        sumSh_d  = sumSh_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        aMsb_d   = aMsb_q;
        bMsb_d   = bMsb_q;
        if (accept) begin
            aSh_d    = in_a_i;
            bSh_d    = in_b_i;
            carry_d  = in_cin_i;
            nibIdx_d = '0;
            sumSh_d  = '0;
            cout_d   = 1'b0;
            ovf_d    = 1'b0;
            aMsb_d   = in_a_i[WIDTH-1];
            bMsb_d   = in_b_i[WIDTH-1];
        end else if (state_q == RUN) begin
            aSh_d   = {{NIB_W{1'b0}}, aSh_q[WIDTH-1:NIB_W]};
            bSh_d   = {{NIB_W{1'b0}}, bSh_q[WIDTH-1:NIB_W]};
            sumSh_d = {sliceSum, sumSh_q[WIDTH-1:NIB_W]};
            carry_d = sliceCout;
            if (lastNib) begin
                cout_d = sliceCout;
                ovf_d  = signedOverflow(aMsb_q, bMsb_q, sliceSum[NIB_W-1]);
            end else begin
                nibIdx_d = nibIdx_q + IDX_W'(1);
            end
        end
    end

    // Datapath registers, all cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nibIdx_q <= '0;
            carry_q  <= 1'b0;
            aSh_q    <= '0;
            bSh_q    <= '0;
            sumSh_q  <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            aMsb_q   <= 1'b0;
            bMsb_q   <= 1'b0;
        end else begin
            nibIdx_q <= nibIdx_d;
            carry_q  <= carry_d;
            aSh_q    <= aSh_d;
            bSh_q    <= bSh_d;
            sumSh_q  <= sumSh_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            aMsb_q   <= aMsb_d;
            bMsb_q   <= bMsb_d;
        end
    end

    assign out_sum_o  = sumSh_q;
    assign out_cout_o = cout_q;
    assign out_ovf_o  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_nibble_serial_adder
//   Self-checking bench for the 16-bit nibble-serial adder: directed cases
//   followed by randomized traffic scoreboarded against plain integer
//   addition.
// ----------------------------------------------------------------------------
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             inCin;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outSum;
    logic             outCout;
    logic             outOvf;

    int errors = 0;
    int checks = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .in_a_i      (inA),
        .in_b_i      (inB),
        .in_cin_i    (inCin),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .out_sum_o   (outSum),
        .out_cout_o  (outCout),
        .out_ovf_o   (outOvf)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference result packed as {cout, ovf, sum}, from integer addition.
    function automatic logic [17:0] refAdd(input logic [15:0] a,
                                           input logic [15:0] b,
                                           input logic        cin);
        logic [16:0] full;
        logic        ovf;
        full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        ovf  = (a[15] == b[15]) && (full[15] != a[15]);
        return {full[16], ovf, full[15:0]};
    endfunction

    function automatic logic [17:0] dutResult();
        return {outCout, outOvf, outSum};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for the accept edge, then count edges until
    // the result becomes valid. Latency is 0 if valid is already up right
    // after the accept edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, output int latency);
        int waitCyc;
        inA     = a;
        inB     = b;
        inCin   = cin;
        inValid = 1'b1;
        #1;
        waitCyc = 0;
        while (!inReady && waitCyc < 20) begin
            tick();
            waitCyc++;
        end
        if (!inReady) begin
            checkOutput("accept_timeout", 32'(inReady), 32'd1);
        end
        tick();
        inValid = 1'b0;
        latency = 0;
        while (!outValid && latency < 20) begin
            tick();
            latency++;
        end
    endtask

    // One complete operation with the sink always ready.
    task automatic runOp(input string tag, input logic [15:0] a,
                         input logic [15:0] b, input logic cin);
        int lat;
        outReady = 1'b1;
        applyStimulus(a, b, cin, lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
        checkOutput({tag, "_result"}, 32'(dutResult()), 32'(refAdd(a, b, cin)));
        tick();
    endtask

    initial begin
        int          lat;
        int          retired;
        int          cyc;
        logic        sawValid;
        logic [17:0] expQ[$];
        logic [17:0] held;

        rst      = 1'b1;
        inValid  = 1'b0;
        inA      = '0;
        inB      = '0;
        inCin    = 1'b0;
        outReady = 1'b1;
        tick();
        tick();

        // Reset state: everything quiet and not ready while reset is high.
        checkOutput("reset_state", {12'd0, inReady, outValid, 18'(dutResult())}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", 32'(inReady), 32'd1);

        // Basic sums, carry ripple, signed overflow and carry-in.
        runOp("sum_5555",    16'h1234, 16'h4321, 1'b0);
        runOp("ripple_all",  16'hFFFF, 16'h0001, 1'b0);
        runOp("ovf_pos",     16'h7FFF, 16'h0001, 1'b0);
        runOp("ovf_neg",     16'h8000, 16'h8000, 1'b0);
        runOp("cin_nib1",    16'h000F, 16'h0000, 1'b1);

        // Stalled sink: result must hold and ready stay low, even with a
        // new operand pair offered meanwhile.
        outReady = 1'b0;
        applyStimulus(16'h1111, 16'h2222, 1'b0, lat);
        checkOutput("stall_latency", 32'(lat), 32'd4);
        held    = refAdd(16'h1111, 16'h2222, 1'b0);
        inA     = 16'hDEAD;
        inB     = 16'hBEEF;
        inValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_hold", {12'd0, inReady, outValid, 18'(dutResult())},
                        {12'd0, 1'b0, 1'b1, held});
            tick();
        end

        // Release the sink with a new op offered: retire and accept together.
        inA      = 16'h0F0F;
        inB      = 16'h0101;
        inCin    = 1'b0;
        outReady = 1'b1;
        #1;
        checkOutput("b2b_ready", 32'(inReady), 32'd1);
        tick();
        inValid = 1'b0;
        checkOutput("b2b_valid_drop", 32'(outValid), 32'd0);
        lat = 0;
        while (!outValid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("b2b_latency", 32'(lat), 32'd4);
        checkOutput("b2b_result", 32'(dutResult()), 32'(refAdd(16'h0F0F, 16'h0101, 1'b0)));
        tick();

        // Reset in the middle of a run abandons the op.
        inA     = 16'h5555;
        inB     = 16'h1111;
        inCin   = 1'b0;
        inValid = 1'b1;
        #1;
        tick();
        inValid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("ready_in_reset", 32'(inReady), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("ready_after_abort", {30'd0, inReady, outValid}, {30'd0, 1'b1, 1'b0});
        sawValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sawValid = sawValid | outValid;
            tick();
        end
        checkOutput("abort_no_valid", 32'(sawValid), 32'd0);
        runOp("after_abort", 16'h00FF, 16'h0001, 1'b0);

        // Random traffic with gaps on both sides; operands change every
        // cycle so anything sampled outside an accept edge shows up.
        retired = 0;
        cyc     = 0;
        while (retired < 1000 && cyc < 40000) begin
            inA      = 16'($urandom);
            inB      = 16'($urandom);
            inCin    = 1'($urandom);
            inValid  = ($urandom_range(0, 3) != 0);
            outReady = ($urandom_range(0, 3) != 0);
            #1;
            if (inValid && inReady) begin
                expQ.push_back(refAdd(inA, inB, inCin));
            end
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("rnd_spurious", 32'(outValid), 32'd0);
                end else begin
                    checkOutput("rnd_result", 32'(dutResult()), 32'(expQ.pop_front()));
                end
                retired++;
            end
            tick();
            cyc++;
        end
        inValid = 1'b0;
        checkOutput("rnd_retired", 32'(retired), 32'd1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
